// File: rtl/dyn_euler_stepper.sv
// dyn_euler_stepper: fixed-step forward-Euler sequencer around an external
// combinational motor-derivative solver. State registers i_est/w_est drive
// the solver operands directly; each step waits a settle window, then adds
// the derivatives scaled by 2^-DT_SHIFT with saturation to signed 64 bits.
//
// state    | meaning
// ---------+----------------------------------------------------------
// S_IDLE   | waiting for start; outputs hold results of the last run
// S_LOAD   | apply latched operands, optional initial state, clear stats
// S_EVAL   | solver settling; settle down-counter runs to terminal count
// S_UPDATE | capture derivatives, integrate, count the step
// S_DONE   | one-cycle done pulse, then back to idle
module dyn_euler_stepper #(
  parameter int DT_SHIFT      = 16,
  parameter int SETTLE_CYCLES = 2,
  parameter int STEP_W        = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic              abort,
  input  logic              init_en,
  input  logic [STEP_W-1:0] n_steps,
  input  logic [63:0]       v_in,
  input  logic [63:0]       load_in,
  input  logic [63:0]       i_init,
  input  logic [63:0]       w_init,
  input  logic [127:0]      di_dt,
  input  logic [127:0]      dw_dt,
  output logic [63:0]       sv,
  output logic [63:0]       sload,
  output logic [63:0]       i_est,
  output logic [63:0]       w_est,
  output logic              busy,
  output logic              done,
  output logic              sat,
  output logic [STEP_W-1:0] step_count
);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_LOAD   = 3'd1,
    S_EVAL   = 3'd2,
    S_UPDATE = 3'd3,
    S_DONE   = 3'd4
  } state_t;

  // Settle counter reloads to SETTLE_CYCLES-1 and leaves EVAL on reaching 0,
  // giving exactly SETTLE_CYCLES cycles in EVAL per step.
  localparam logic [7:0] SETTLE_TC = 8'(SETTLE_CYCLES - 1);

  state_t              state_q, state_d;
  logic [7:0]          settle_q, settle_d;
  logic [63:0]         v_lat_q, v_lat_d;
  logic [63:0]         load_lat_q, load_lat_d;
  logic [STEP_W-1:0]   n_lat_q, n_lat_d;
  logic                init_lat_q, init_lat_d;
  logic [63:0]         sv_q, sv_d;
  logic [63:0]         sload_q, sload_d;
  logic [63:0]         i_est_q, i_est_d;
  logic [63:0]         w_est_q, w_est_d;
  logic                busy_q, busy_d;
  logic                done_q, done_d;
  logic                sat_q, sat_d;
  logic [STEP_W-1:0]   step_q, step_d;

  logic [64:0]         i_upd, w_upd;
  logic [STEP_W-1:0]   step_inc;

  // Returns {saturated, value}: acc + (deriv >>> DT_SHIFT) clamped to int64.
  function automatic logic [64:0] sat_add(input logic [63:0] acc, input logic [127:0] deriv);
    logic signed [127:0] delta;
    logic signed [128:0] sum;
    logic [64:0]         res;
    delta = $signed(deriv) >>> DT_SHIFT;
    sum   = $signed({{65{acc[63]}}, acc}) + $signed({delta[127], delta});
    if (sum[128:63] == {66{sum[63]}}) begin
      res = {1'b0, sum[63:0]};
    end else if (sum[128]) begin
      res = {1'b1, 64'h8000_0000_0000_0000};
    end else begin
      res = {1'b1, 64'h7FFF_FFFF_FFFF_FFFF};
    end
    return res;
  endfunction

  assign i_upd    = sat_add(i_est_q, di_dt);
  assign w_upd    = sat_add(w_est_q, dw_dt);
  assign step_inc = step_q + STEP_W'(1);

  // Next-state and next-output logic for the sequencer.
  always_comb begin
    state_d    = state_q;
    settle_d   = settle_q;
    v_lat_d    = v_lat_q;
    load_lat_d = load_lat_q;
    n_lat_d    = n_lat_q;
    init_lat_d = init_lat_q;
    sv_d       = sv_q;
    sload_d    = sload_q;
    i_est_d    = i_est_q;
    w_est_d    = w_est_q;
    busy_d     = busy_q;
    done_d     = 1'b0;
    sat_d      = sat_q;
    step_d     = step_q;

    case (state_q)
      S_IDLE: begin
        if (start) begin
          state_d    = S_LOAD;
          v_lat_d    = v_in;
          load_lat_d = load_in;
          n_lat_d    = n_steps;
          init_lat_d = init_en;
          busy_d     = 1'b1;
        end
      end
      S_LOAD: begin
        if (abort) begin
          state_d = S_IDLE;
          busy_d  = 1'b0;
        end else begin
          sv_d    = v_lat_q;
          sload_d = load_lat_q;
          if (init_lat_q) begin
            i_est_d = i_init;
            w_est_d = w_init;
          end
          step_d = '0;
          sat_d  = 1'b0;
          if (n_lat_q == '0) begin
            state_d = S_DONE;
            done_d  = 1'b1;
            busy_d  = 1'b0;
          end else begin
            state_d  = S_EVAL;
            settle_d = SETTLE_TC;
          end
        end
      end
      S_EVAL: begin
        if (abort) begin
          state_d = S_IDLE;
          busy_d  = 1'b0;
        end else if (settle_q == 8'd0) begin
          state_d = S_UPDATE;
        end else begin
          settle_d = settle_q - 8'd1;
        end
      end
      S_UPDATE: begin
        if (abort) begin
          state_d = S_IDLE;
          busy_d  = 1'b0;
        end else begin
          i_est_d = i_upd[63:0];
          w_est_d = w_upd[63:0];
          sat_d   = sat_q | i_upd[64] | w_upd[64];
          step_d  = step_inc;
          if (step_inc == n_lat_q) begin
            state_d = S_DONE;
            done_d  = 1'b1;
            busy_d  = 1'b0;
          end else begin
            state_d  = S_EVAL;
            settle_d = SETTLE_TC;
          end
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
        busy_d  = 1'b0;
      end
    endcase
  end

  // All sequencer state and registered outputs; async reset clears everything.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= S_IDLE;
      settle_q   <= '0;
      v_lat_q    <= '0;
      load_lat_q <= '0;
      n_lat_q    <= '0;
      init_lat_q <= 1'b0;
      sv_q       <= '0;
      sload_q    <= '0;
      i_est_q    <= '0;
      w_est_q    <= '0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      sat_q      <= 1'b0;
      step_q     <= '0;
    end else begin
      state_q    <= state_d;
      settle_q   <= settle_d;
      v_lat_q    <= v_lat_d;
      load_lat_q <= load_lat_d;
      n_lat_q    <= n_lat_d;
      init_lat_q <= init_lat_d;
      sv_q       <= sv_d;
      sload_q    <= sload_d;
      i_est_q    <= i_est_d;
      w_est_q    <= w_est_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
      sat_q      <= sat_d;
      step_q     <= step_d;
    end
  end

  assign sv         = sv_q;
  assign sload      = sload_q;
  assign i_est      = i_est_q;
  assign w_est      = w_est_q;
  assign busy       = busy_q;
  assign done       = done_q;
  assign sat        = sat_q;
  assign step_count = step_q;

endmodule

// File: doc/dyn_euler_stepper.md
Name: dyn_euler_stepper

Overview:
- Sequences the combinational motor-derivative solver (di_dt/dw_dt from v, load, i, w) as a fixed-step forward-Euler integrator.
- On start, latches inputs and initial state, then drives the solver's i/w operands from its own state registers.
- Each step waits a settle window, then integrates the returned derivatives scaled by dt = 2^-DT_SHIFT. Repeats for n_steps and pulses done.

Parameters:
- DT_SHIFT, 16: integration step is 2^-DT_SHIFT; derivative is arithmetic-right-shifted by this amount. Range 0..127.
- SETTLE_CYCLES, 2: cycles the solver outputs are allowed to settle after i/w change before capture. Range 1..255.
- STEP_W, 16: width of n_steps and step_count.

Ports:
- clk  in  1  single clock
- rst_n  in  1  asynchronous active-low reset
- start  in  1  begin a run; sampled only in IDLE
- abort  in  1  cancel run; honoured in LOAD/EVAL/UPDATE
- init_en  in  1  sampled with start: 1 loads i_init/w_init, 0 keeps current i_est/w_est
- n_steps  in  STEP_W  number of Euler steps, sampled with start
- v_in  in  64  applied voltage, sampled with start
- load_in  in  64  applied load, sampled with start
- i_init  in  64  signed initial current
- w_init  in  64  signed initial speed
- di_dt  in  128  signed derivative from solver
- dw_dt  in  128  signed derivative from solver
- sv  out  64  voltage operand to solver (registered)
- sload  out  64  load operand to solver (registered)
- i_est  out  64  signed current state; also solver i operand
- w_est  out  64  signed speed state; also solver w operand
- busy  out  1  high in LOAD, EVAL, UPDATE
- done  out  1  one-cycle pulse at run completion
- sat  out  1  sticky: an update saturated during the current/last run
- step_count  out  STEP_W  completed updates in the current/last run

Behaviour:
- Reset values: all outputs 0; state IDLE; settle counter 0.
- States and transitions:
  - IDLE: start=1 -> LOAD, capturing v_in, load_in, n_steps, init_en. Start while busy is ignored.
  - LOAD (1 cycle): sv<=v_in, sload<=load_in. If init_en, i_est<=i_init and w_est<=w_init. Clear step_count and sat. n_steps=0 -> DONE, else -> EVAL.
  - EVAL: counts SETTLE_CYCLES cycles, then -> UPDATE.
  - UPDATE (1 cycle): captures di_dt/dw_dt and updates i_est/w_est; step_count+1. If step_count+1 == n_steps -> DONE, else -> EVAL.
  - DONE (1 cycle): done=1, -> IDLE.
- Timing: with the start-sampling edge as edge 0, done is high in the cycle following edge 1+N*(SETTLE_CYCLES+1), where N=n_steps.
- Update arithmetic:
  - delta = di_dt >>> DT_SHIFT (arithmetic, floor toward -inf).
  - sum = sign-extended i_est + delta, computed in 129 bits.
  - sum > 2^63-1 -> i_est=0x7FFF_FFFF_FFFF_FFFF; sum < -2^63 -> i_est=0x8000_0000_0000_0000. Either case sets sat.
  - Same rules for w_est with dw_dt.
  - sat is sticky until the next LOAD.
- abort:
  - In LOAD/EVAL/UPDATE: -> IDLE next edge; no done; any update in that cycle is suppressed. i_est, w_est, step_count and sat hold.
  - Ignored in IDLE/DONE.
  - abort and start together in IDLE: start wins.
- sv/sload/i_est/w_est are stable throughout EVAL.
- step_count holds its value after DONE until the next LOAD.
- rst_n low at any time, including mid-run: immediate return to reset values; no done pulse.

Test Plan:
1. Defaults; init_en=1, i_init=0, w_init=0, n_steps=1, bench solver model returns di_dt=1000, dw_dt=0 -> i_est=0 (1000>>>16), done at edge 4. Repeat with DT_SHIFT=4 -> i_est=62, then di_dt=-1000 -> i_est=-63.
2. DT_SHIFT=0, SETTLE_CYCLES=2, n_steps=4, constant di_dt=5, dw_dt=-3, init 0 -> i_est=20, w_est=-12, step_count=4, done high following edge 13, busy low after.
3. i_init=0x7FFF_FFFF_FFFF_FFF0, DT_SHIFT=0, di_dt=0x100 -> i_est=0x7FFF_FFFF_FFFF_FFFF, sat=1. Next run with no overflow -> sat cleared at LOAD and stays 0.
4. n_steps=0 -> LOAD then DONE; done following edge 1; i_est=i_init; step_count=0.
5. n_steps=10, abort asserted in the 3rd EVAL window -> IDLE, no done, step_count=2, i_est holds. start pulses during the run are ignored.
6. rst_n low mid-EVAL -> all outputs 0 asynchronously. Run with init_en=0 after a prior run continues from the held i_est/w_est.
